// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multiply/divide unit holding the LO/HI special registers.
//   MULT/MULTU form a full 2*DATA_BITS product (hi = upper half, lo = lower).
//   DIV/DIVU run a restoring shift-subtract divider, one quotient bit per
//   cycle (lo = quotient, hi = remainder). MTLO/MTHI write LO/HI directly.
//
//   Optional feature macro: MULDIV_FAST_MUL_EN
//     defined   -> MULT/MULTU complete at the accepting edge (no MUL state)
//     undefined -> MULT/MULTU use a radix-2 shift-add over DATA_BITS cycles
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   start  : request strobe, qualified with op
//   op     : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTLO, 5 MTHI, 6/7 no-op
//   a      : rs operand (multiplicand / dividend / MTLO-MTHI source)
//   b      : rt operand (multiplier / divisor)
//   flush  : abort an in-flight operation, or cancel a same-cycle start
//   lo, hi : LO/HI special registers
//   busy   : multi-cycle operation in flight
//   done   : one-cycle pulse after a multi-cycle result lands in LO/HI
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [DATA_BITS-1:0] a,
  input  logic [DATA_BITS-1:0] b,
  input  logic                 flush,
  output logic [DATA_BITS-1:0] lo,
  output logic [DATA_BITS-1:0] hi,
  output logic                 busy,
  output logic                 done
);

  localparam int W  = DATA_BITS;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTLO  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_NOP6  = 3'd6,
    OP_NOP7  = 3'd7
  } op_t;

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [W-1:0]  work_hi_q;   // partial product high half / partial remainder
  logic [W-1:0]  work_lo_q;   // multiplier being consumed / dividend -> quotient
  logic [W-1:0]  operand_q;   // multiplicand or divisor magnitude
  logic          neg_lo_q;    // negate quotient, or negate whole product
  logic          neg_hi_q;    // negate remainder
  logic [W-1:0]  lo_q, hi_q;
  logic          done_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  op_t  op_e;
  logic is_mul_op, is_div_op, is_signed;
  logic accept, iterating, last_iter, write_res;

  assign op_e      = op_t'(op);
  assign is_mul_op = (op_e == OP_MULT) || (op_e == OP_MULTU);
  assign is_div_op = (op_e == OP_DIV)  || (op_e == OP_DIVU);
  assign is_signed = (op_e == OP_MULT) || (op_e == OP_DIV);

  // A flush in IDLE kills a start arriving in the same cycle.
  assign accept    = start && (state_q == IDLE) && !flush &&
                     (op_e inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTLO, OP_MTHI});
  assign iterating = (state_q != IDLE);
  assign last_iter = (cnt_q == CW'(W - 1));
  // Flush beats the final iteration: the result is dropped.
  assign write_res = iterating && last_iter && !flush;

  // Signed ops work on magnitudes; signs are reapplied when the result lands.
  // The most negative value maps to itself, which is the correct unsigned
  // magnitude.
  logic         a_neg, b_neg, b_zero;
  logic [W-1:0] a_mag, b_mag;

  assign a_neg  = is_signed & a[W-1];
  assign b_neg  = is_signed & b[W-1];
  assign b_zero = (b == '0);
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] a_ext, b_ext, fast_prod;

  assign a_ext     = {{W{a_neg}}, a};
  assign b_ext     = {{W{b_neg}}, b};
  assign fast_prod = a_ext * b_ext;
`endif

  // ---------------------------------------------------------------------------
  // One iteration of the shift-add multiplier / restoring divider
  // ---------------------------------------------------------------------------
  logic [W:0]     mul_sum, rem_shift, rem_diff;
  logic [W-1:0]   step_hi, step_lo;
  logic [2*W-1:0] product, product_fix;
  logic [W-1:0]   res_lo, res_hi;

  assign mul_sum   = {1'b0, work_hi_q} + ({1'b0, operand_q} & {(W+1){work_lo_q[0]}});
  assign rem_shift = {work_hi_q, work_lo_q[W-1]};
  // Bit W set means the trial subtraction borrowed (remainder < divisor).
  assign rem_diff  = rem_shift - {1'b0, operand_q};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    step_hi = work_hi_q;
    step_lo = work_lo_q;
    if (state_q == MUL) begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], work_lo_q[W-1:1]};
    end else if (state_q == DIV) begin
      if (!rem_diff[W]) begin
        step_hi = rem_diff[W-1:0];
        step_lo = {work_lo_q[W-2:0], 1'b1};
      end else begin
        step_hi = rem_shift[W-1:0];
        step_lo = {work_lo_q[W-2:0], 1'b0};
      end
    end
  end

  assign product     = {step_hi, step_lo};
  assign product_fix = neg_lo_q ? -product : product;

  always_comb begin
    res_lo = neg_lo_q ? -step_lo : step_lo;
    res_hi = neg_hi_q ? -step_hi : step_hi;
    if (state_q == MUL) begin
      res_lo = product_fix[W-1:0];
      res_hi = product_fix[2*W-1:W];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && is_div_op) begin
          state_d = DIV;
        end else if (accept && is_mul_op) begin
`ifdef MULDIV_FAST_MUL_EN
          state_d = IDLE;
`else
          state_d = MUL;
`endif
        end
      end
      MUL, DIV: begin
        if (flush || last_iter) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and LO/HI
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      operand_q <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (accept) begin
        cnt_q     <= '0;
        work_hi_q <= '0;
        unique case (op_e)
          OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
            lo_q <= fast_prod[W-1:0];
            hi_q <= fast_prod[2*W-1:W];
`else
            work_lo_q <= b_mag;
            operand_q <= a_mag;
            neg_lo_q  <= a_neg ^ b_neg;
            neg_hi_q  <= 1'b0;
`endif
          end
          OP_DIV, OP_DIVU: begin
            work_lo_q <= a_mag;
            operand_q <= b_mag;
            // Divide by zero leaves an all-ones quotient unsigned; the
            // remainder magnitude equals |a| and re-signs back to a.
            neg_lo_q  <= (a_neg ^ b_neg) & ~b_zero;
            neg_hi_q  <= a_neg;
          end
          OP_MTLO: lo_q <= a;
          OP_MTHI: hi_q <= a;
          default: ;
        endcase
      end

      if (iterating && !flush) begin
        cnt_q     <= cnt_q + CW'(1);
        work_hi_q <= step_hi;
        work_lo_q <= step_lo;
      end

      if (write_res) begin
        lo_q   <= res_lo;
        hi_q   <= res_hi;
        done_q <= 1'b1;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign lo   = lo_q;
  assign hi   = hi_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (DATA_BITS = 32): a table of known
//   vectors, hand-written flush/reset/ignore sequences, and random operations
//   checked against an arithmetic reference model of LO/HI.
//   Honours MULDIV_FAST_MUL_EN for the expected multiply latency.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W       = 32;
  localparam int DIV_LAT = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 32;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         busy;
  logic         done;

  muldiv_unit #(.DATA_BITS(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .lo    (lo),
    .hi    (hi),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Bench-side view of what LO/HI must hold.
  logic [W-1:0] m_lo, m_hi;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int op_latency(input logic [2:0] o);
    if (o <= 3'd1)      return MUL_LAT;
    else if (o <= 3'd3) return DIV_LAT;
    else                return 0;
  endfunction

  // Reference model: plain arithmetic on 64-bit integers.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                inout logic [W-1:0] lo_m, inout logic [W-1:0] hi_m);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = 64'(sx * sy); lo_m = p[31:0]; hi_m = p[63:32]; end
      3'd1: begin p = {32'b0, x} * {32'b0, y}; lo_m = p[31:0]; hi_m = p[63:32]; end
      3'd2: begin
        if (y == 0) begin lo_m = '1; hi_m = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin lo_m = 32'h8000_0000; hi_m = '0; end
        else begin q = sx / sy; r = sx % sy; lo_m = 32'(q); hi_m = 32'(r); end
      end
      3'd3: begin
        if (y == 0) begin lo_m = '1; hi_m = x; end
        else begin lo_m = x / y; hi_m = x % y; end
      end
      3'd4: lo_m = x;
      3'd5: hi_m = x;
      default: ;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_lo = '0;
    m_hi = '0;
  endtask

  // Drive one start strobe; returns just after the accepting edge.
  task automatic start_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Over n cycles, done and busy must both stay low.
  task automatic watch_quiet(input int n, input string tag);
    int dn = 0;
    int bz = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (busy) bz++;
    end
    check({tag, " done pulses"}, dn, 0);
    check({tag, " busy cycles"}, bz, 0);
  endtask

  // Full operation: latency, done pulse, pulse width and LO/HI.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] elo, input logic [W-1:0] ehi);
    int busy_cycles = 0;
    int done_cnt    = 0;
    bit ended       = 1'b0;
    int lat;
    lat = op_latency(o);
    start_op(o, x, y);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) done_cnt++;
      if (!busy) begin
        ended = 1'b1;
        break;
      end
    end
    check({tag, " finished"}, 64'(ended), 64'd1);
    check({tag, " busy cycles"}, busy_cycles, lat);
    check({tag, " done count"}, done_cnt, (lat > 0) ? 1 : 0);
    check({tag, " lo"}, lo, elo);
    check({tag, " hi"}, hi, ehi);
    @(negedge clk);
    check({tag, " done width"}, 64'(done), 64'd0);
    if (!ended) do_reset();
    else begin
      m_lo = elo;
      m_hi = ehi;
    end
  endtask

  initial begin
    logic [2:0]   ro;
    logic [W-1:0] rx, ry, elo, ehi;
    int           done_cnt;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA, 32'hFFFF_FFFF};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[3]  = '{3'd3, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0064};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    vecs[5]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001};
    vecs[6]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
    vecs[7]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h4000_0000};
    vecs[9]  = '{3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    vecs[10] = '{3'd3, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0DEA_DBEE, 32'h0000_000F};
    vecs[11] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001};

    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0; flush = 1'b0;
    m_lo = '0; m_hi = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("reset lo", lo, 0);
    check("reset hi", hi, 0);
    check("reset busy", 64'(busy), 0);
    check("reset done", 64'(done), 0);

    // Table vectors
    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi);

    // MTLO then DIVU 10/3 flushed at iteration 10
    run_op("mtlo", 3'd4, 32'h1234_5678, 32'h0, 32'h1234_5678, m_hi);
    start_op(3'd3, 32'd10, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush10 busy", 64'(busy), 0);
    check("flush10 lo", lo, 32'h1234_5678);
    check("flush10 hi", hi, m_hi);
    watch_quiet(40, "flush10");

    // Flush colliding with the final divide iteration
    start_op(3'd3, 32'd100, 32'd7);
    repeat (31) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_last busy", 64'(busy), 0);
    check("flush_last done", 64'(done), 0);
    check("flush_last lo", lo, m_lo);
    check("flush_last hi", hi, m_hi);

    // Flush in IDLE cancels a same-cycle start
    @(negedge clk);
    op = 3'd4; a = 32'h5555_5555; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("idle_flush lo", lo, m_lo);
    start_op(3'd2, 32'd50, 32'd5);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("idle_flush2 lo", lo, m_lo);
    @(negedge clk);
    check("idle_flush2 busy", 64'(busy), 0);

`ifndef MULDIV_FAST_MUL_EN
    // Flush in the middle of a multi-cycle multiply
    start_op(3'd1, 32'h0000_1234, 32'h0000_5678);
    repeat (4) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("mul_flush busy", 64'(busy), 0);
    check("mul_flush lo", lo, m_lo);
    check("mul_flush hi", hi, m_hi);
    watch_quiet(40, "mul_flush");
`endif

    // No-op opcodes leave everything alone
    start_op(3'd6, 32'hFFFF_0000, 32'h1);
    @(negedge clk);
    check("nop6 busy", 64'(busy), 0);
    check("nop6 lo", lo, m_lo);
    start_op(3'd7, 32'hFFFF_0000, 32'h1);
    @(negedge clk);
    check("nop7 hi", hi, m_hi);

    // Start while busy ignored, then reset at iteration 20
    start_op(3'd2, 32'h0000_1000, 32'h0000_0003);
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = 3'd5; a = 32'hAAAA_0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_mthi hi", hi, m_hi);
    check("busy_mthi busy", 64'(busy), 1);
    repeat (14) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst20 lo", lo, 0);
    check("rst20 hi", hi, 0);
    check("rst20 busy", 64'(busy), 0);
    rst_n = 1'b1;
    m_lo = '0;
    m_hi = '0;
    watch_quiet(40, "rst20");

    // Reset wins over a same-cycle MTLO
    run_op("pre_rst mtlo", 3'd4, 32'h1111_2222, 32'h0, 32'h1111_2222, m_hi);
    @(negedge clk);
    rst_n = 1'b0; op = 3'd4; a = 32'h5555_0000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("rst_prio lo", lo, 0);
    rst_n = 1'b1;
    m_lo = '0;
    m_hi = '0;

    // Random operations against the model
    for (int k = 0; k < 60; k++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 5))
        0: ry = '0;
        1: ry = 32'($urandom_range(1, 15));
        2: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        3: rx = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      elo = m_lo;
      ehi = m_hi;
      model(ro, rx, ry, elo, ehi);
      run_op($sformatf("rand%0d op%0d a=%h b=%h", k, ro, rx, ry), ro, rx, ry, elo, ehi);
    end

    // A done pulse must not follow a quiet stretch
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("tail done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: DATA_BITS, default 32, operand and LO/HI register width.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request strobe, qualified with op; sampled every cycle.
REQ-005 op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTLO, 5 MTHI, 6/7 no-op.
REQ-006 a  input  DATA_BITS  rs operand: multiplicand, dividend, or MTLO/MTHI source.
REQ-007 b  input  DATA_BITS  rt operand: multiplier or divisor.
REQ-008 flush  input  1  aborts any in-progress multi-cycle operation.
REQ-009 lo  output  DATA_BITS  LO special register; feeds regfile write-back data select.
REQ-010 hi  output  DATA_BITS  HI special register; feeds regfile write-back data select.
REQ-011 busy  output  1  operation in flight; pipeline stalls any MFLO/MFHI/muldiv while high.
REQ-012 done  output  1  one-cycle pulse after a multi-cycle result is written to LO/HI.

Function
REQ-013 FSM states: IDLE, MUL, DIV; busy = (state != IDLE), registered.
REQ-014 Accept: start=1 with busy=0 and op in 0..5; start while busy=1 is ignored with no side effect.
REQ-015 MTLO/MTHI: lo<=a or hi<=a at the accepting edge; busy stays 0; no done pulse.
REQ-016 MULT/MULTU: 2*DATA_BITS product, signed or unsigned; hi<=upper half, lo<=lower half.
REQ-017 DIV/DIVU: restoring shift-subtract, one quotient bit per cycle, on operand magnitudes latched at accept.
REQ-018 Divide timing: IDLE->DIV at accept edge, then exactly DATA_BITS iteration edges; the last iteration edge writes lo/hi, returns to IDLE, drops busy, and raises done for one cycle.
REQ-019 Signed divide: quotient negated iff sign(a)!=sign(b); remainder takes sign(a); lo<=quotient, hi<=remainder.
REQ-020 Divide by zero (signed or unsigned): lo<={DATA_BITS{1}}, hi<=a; full latency still applies.
REQ-021 Signed overflow (a=0x80000000, b=-1): lo<=0x80000000, hi<=0.
REQ-022 lo/hi change only at result-write edges, MTLO/MTHI edges, and reset; they hold otherwise.
REQ-023 flush=1 in MUL or DIV: return to IDLE next edge; lo/hi unchanged; no done pulse.
REQ-024 flush=1 in IDLE: cancels a start seen in the same cycle.
REQ-025 flush and the final iteration on the same edge: flush wins; result discarded; no done.
REQ-026 op 6/7 with start=1: no state change.

Reset
REQ-027 rst_n=0 at a rising edge: state<=IDLE, lo<=0, hi<=0, busy<=0, done<=0, iteration counter and working registers cleared.
REQ-028 Reset during MUL/DIV aborts the operation; no done pulse on the edge after reset releases.
REQ-029 Reset has priority over flush and start.

Configuration
REQ-030 Macro MULDIV_FAST_MUL_EN defined: MULT/MULTU write lo/hi at the accepting edge; no MUL state entered; busy stays 0; no done pulse.
REQ-031 Macro MULDIV_FAST_MUL_EN undefined: MULT/MULTU use the MUL state, radix-2 shift-add over DATA_BITS edges; timing, done and flush behave exactly as divide (REQ-018, REQ-023, REQ-025).
REQ-032 Results are bit-identical with and without MULDIV_FAST_MUL_EN.

Verification
REQ-033 MULT a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; latency 0 with macro, 32 cycles without.
REQ-034 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> busy high exactly 32 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF, done pulse one cycle.
REQ-036 DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064 after 32 cycles.
REQ-037 MTLO 0x12345678, then DIVU 10/3 with flush at iteration 10 -> busy low next cycle, lo=0x12345678, hi unchanged, done never asserted.
REQ-038 During DIV busy: start with MTHI 0xAAAA0000 -> ignored. Then rst_n=0 at iteration 20 -> lo=hi=0, busy=0, no done afterwards.
